sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's 8x8 FIFO. Data width, depth and watermark thresholds are generic. Adds overflow/underflow protection, occupancy count, almost-full/almost-empty watermarks, a read-valid strobe and an optional first-word-fall-through mode. Used as the generic single-clock buffer between producer/consumer stages.

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_param_if.sv | 40 ++++
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/sync_fifo_param.sv | 105 ++++++++++
 tb/tb_sync_fifo_param.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Default constants and clog2 helper for the parametrised FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_AF_THRESH = 6;
    localparam int DEF_AE_THRESH = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param_if
// Description : Producer/consumer bundle of the FIFO; master drives requests.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_param_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) ();
    localparam int ADDR_W = clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_mem
// Description : DEPTH x DATA_W dual-port array, synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  wire logic              clk,
    input  wire logic              i_wr_en,
    input  wire logic [ADDR_W-1:0] i_wr_addr,
    input  wire logic [DATA_W-1:0] i_wr_data,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    output logic      [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with watermarks and error
//               pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input wire logic         clk,
    input wire logic         rst,
    sync_fifo_param_if.slave bus
);
    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0] c_AF_LVL = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] c_AE_LVL = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0] c_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_empty;
    logic              w_full;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rd_data;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_rd_ok = bus.rd_en && !w_empty;
    // A full FIFO can still accept a write when a read frees a slot this edge.
    assign w_wr_ok = bus.wr_en && (!w_full || w_rd_ok);

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (bus.data_in),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + c_ONE;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
            r_overflow  <= bus.wr_en && !w_wr_ok;
            r_underflow <= bus.rd_en && w_empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.data_out = w_rd_data;
    assign bus.rd_valid = !w_empty;
`else
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) r_data_out <= w_rd_data;
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.rd_valid = r_rd_valid;
`endif

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = r_count;
    assign bus.almost_full  = (r_count >= c_AF_LVL);
    assign bus.almost_empty = (r_count <= c_AE_LVL);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Directed self-checking bench for sync_fifo_param (8x8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) bus ();

    sync_fifo_param #(
        .DATA_W    (8),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, then settle 1 ns past the edge.
    task automatic cycle(input logic wr, input logic [7:0] din, input logic rd);
        bus.wr_en   = wr;
        bus.data_in = din;
        bus.rd_en   = rd;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycle(0, 8'h00, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_ae", bus.almost_empty, 1);
        chk("rst_af", bus.almost_full, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_rdv", bus.rd_valid, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_udf", bus.underflow, 0);

        for (int i = 1; i <= 8; i++) begin
            cycle(1, 8'(i), 0);
            chk("fill_count", bus.count, i);
            chk("fill_af", bus.almost_full, (i >= 6) ? 1 : 0);
            chk("fill_full", bus.full, (i == 8) ? 1 : 0);
        end
        cycle(1, 8'hFF, 0);
        chk("ovf_pulse", bus.overflow, 1);
        chk("ovf_count", bus.count, 8);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 8'h00, 1);
            chk("drain_data", bus.data_out, i);
            chk("drain_rdv", bus.rd_valid, 1);
            chk("drain_ovf", bus.overflow, 0);
        end
        chk("drain_empty", bus.empty, 1);
        cycle(0, 8'h00, 0);
        chk("idle_rdv", bus.rd_valid, 0);
        chk("idle_hold", bus.data_out, 8'h08);

        for (int i = 0; i < 8; i++) cycle(1, 8'(8'h11 + i), 0);
        chk("refill_full", bus.full, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 8'hAA, 1);
            chk("both_data", bus.data_out, 8'h11 + i);
            chk("both_count", bus.count, 8);
            chk("both_ovf", bus.overflow, 0);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 8'h00, 1);
            chk("aa_data", bus.data_out, 8'hAA);
        end
        chk("aa_empty", bus.empty, 1);

        cycle(0, 8'h00, 1);
        chk("udf_pulse", bus.underflow, 1);
        chk("udf_rdv", bus.rd_valid, 0);
        chk("udf_hold", bus.data_out, 8'hAA);
        cycle(1, 8'h5C, 1);
        chk("ewr_udf", bus.underflow, 1);
        chk("ewr_count", bus.count, 1);
        cycle(0, 8'h00, 1);
        chk("ewr_data", bus.data_out, 8'h5C);
        chk("ewr_udf_clr", bus.underflow, 0);
        chk("ewr_empty", bus.empty, 1);

        cycle(1, 8'h30, 0); q.push_back(8'h30);
        cycle(1, 8'h31, 0); q.push_back(8'h31);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 8'(8'h40 + i), 0);
            q.push_back(8'(8'h40 + i));
            chk("wrap_cnt3", bus.count, 3);
            chk("wrap_ae3", bus.almost_empty, 0);
            chk("wrap_flags3", {bus.empty, bus.full}, 2'b00);
            cycle(0, 8'h00, 1);
            exp_d = q.pop_front();
            chk("wrap_data", bus.data_out, exp_d);
            chk("wrap_ae2", bus.almost_empty, 1);
            chk("wrap_flags2", {bus.empty, bus.full}, 2'b00);
        end

        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h70 + i), 0);
        chk("pre_rst_count", bus.count, 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", bus.count, 0);
        chk("arst_empty", bus.empty, 1);
        chk("arst_full", bus.full, 0);
        chk("arst_ae", bus.almost_empty, 1);
        chk("arst_af", bus.almost_full, 0);
        chk("arst_dout", bus.data_out, 0);
        chk("arst_rdv", bus.rd_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(0, 8'h00, 1);
        chk("post_rst_udf", bus.underflow, 1);
        chk("post_rst_count", bus.count, 0);

`ifdef SYNC_FIFO_FWFT_EN
        cycle(1, 8'h3C, 0);
        chk("fwft_data", bus.data_out, 8'h3C);
        chk("fwft_rdv", bus.rd_valid, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
